// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared types and constants for the router packet source
//
// Purpose : tx state enum, address/length limits, header field layout and
//           the header packing helper used by router_pkt_tx and router_tx_buf.
// Ports   : none (package).
package router_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      HDR,
      PAYLOAD,
      PARITY,
      WAIT_ERR
   } tx_state_t;

   localparam logic [1:0] ADDR_INVALID = 2'b11;
   localparam int         MAX_LEN      = 63;
   localparam int         BUF_DEPTH    = MAX_LEN + 1;
   localparam int         PTR_W        = $clog2(BUF_DEPTH);

   // Header byte layout: length in [7:2], destination address in [1:0].
   localparam int HDR_LEN_MSB  = 7;
   localparam int HDR_LEN_LSB  = 2;
   localparam int HDR_ADDR_MSB = 1;
   localparam int HDR_ADDR_LSB = 0;

   function automatic logic [7:0] make_header(input logic [5:0] len,
                                              input logic [1:0] addr);
      logic [7:0] h;
      h = '0;
      h[HDR_LEN_MSB:HDR_LEN_LSB]   = len;
      h[HDR_ADDR_MSB:HDR_ADDR_LSB] = addr;
      return h;
   endfunction

endpackage

// File: rtl/router_tx_buf.sv
// rtl/router_tx_buf.sv - payload byte buffer for the router packet source
//
// Purpose : 64x8 register buffer, synchronous write, combinational read.
//           Both pointers return to 0 on clr so every packet starts at entry 0.
// Ports   : clk, rst (sync active-high), clr (per-packet pointer clear),
//           wr_en/wr_data (write at wr_ptr, post-increment),
//           rd_adv (advance rd_ptr), rd_data (mem[rd_ptr], combinational).
module router_tx_buf
   import router_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   input  logic       rd_adv,
   output logic [7:0] rd_data
);

   logic [7:0]       mem [BUF_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_adv) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/router_pkt_tx.sv
// rtl/router_pkt_tx.sv - packet source driving the 1x3 router input port
//
// Purpose : takes a (dest, len) command, buffers len payload bytes from the
//           host, then sends header, payload and parity to the router,
//           stalling on busy, and finally samples the router error flag.
// Ports   : clk, rst (sync active-high)
//           command : start, dest, len, corrupt_par, reject
//           host    : pl_valid, pl_data, pl_ready
//           router  : busy, error, pkt_valid, data_out
//           status  : tx_active, done, pkt_err
module router_pkt_tx
   import router_pkg::*;
#(
   parameter int ERR_WAIT = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [1:0] dest,
   input  logic [5:0] len,
   input  logic       corrupt_par,
   input  logic       pl_valid,
   input  logic [7:0] pl_data,
   output logic       pl_ready,
   input  logic       busy,
   input  logic       error,
   output logic       pkt_valid,
   output logic [7:0] data_out,
   output logic       tx_active,
   output logic       done,
   output logic       pkt_err,
   output logic       reject
);

   localparam logic [3:0] WAIT_INIT = 4'(ERR_WAIT);

   tx_state_t  state;
   logic [1:0] dest_q;
   logic [5:0] len_q;
   logic       corrupt_q;
   logic [7:0] par;
   logic [5:0] cnt;
   logic [3:0] wait_cnt;
   logic [7:0] data_q;

   logic       cmd_ok;
   logic       buf_clr;
   logic       buf_wr;
   logic       buf_adv;
   logic [7:0] buf_data;
   logic       last_byte;

   assign cmd_ok    = (dest != ADDR_INVALID) && (len != 6'd0);
   assign buf_clr   = (state == IDLE) && start && cmd_ok;
   assign buf_wr    = (state == LOAD) && pl_valid;
   assign buf_adv   = (state == PAYLOAD) && !busy;
   assign last_byte = (cnt == len_q - 6'd1);

   router_tx_buf u_buf (
      .clk     (clk),
      .rst     (rst),
      .clr     (buf_clr),
      .wr_en   (buf_wr),
      .wr_data (pl_data),
      .rd_adv  (buf_adv),
      .rd_data (buf_data)
   );

   // Payload bytes come straight from the buffer so consecutive bytes go out
   // back to back; every other state drives the registered byte.
   assign data_out = (state == PAYLOAD) ? buf_data : data_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         dest_q    <= '0;
         len_q     <= '0;
         corrupt_q <= 1'b0;
         par       <= '0;
         cnt       <= '0;
         wait_cnt  <= '0;
         data_q    <= '0;
         pkt_valid <= 1'b0;
         pl_ready  <= 1'b0;
         tx_active <= 1'b0;
         done      <= 1'b0;
         pkt_err   <= 1'b0;
         reject    <= 1'b0;
      end else begin
         done   <= 1'b0;
         reject <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (cmd_ok) begin
                     dest_q    <= dest;
                     len_q     <= len;
                     corrupt_q <= corrupt_par;
                     par       <= make_header(len, dest);
                     cnt       <= '0;
                     pkt_err   <= 1'b0;
                     pl_ready  <= 1'b1;
                     tx_active <= 1'b1;
                     state     <= LOAD;
                  end else begin
                     reject <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (pl_valid) begin
                  par <= par ^ pl_data;
                  if (last_byte) begin
                     cnt       <= '0;
                     pl_ready  <= 1'b0;
                     pkt_valid <= 1'b1;
                     data_q    <= make_header(len_q, dest_q);
                     state     <= HDR;
                  end else begin
                     cnt <= cnt + 6'd1;
                  end
               end
            end
            HDR: begin
               if (!busy) begin
                  state <= PAYLOAD;
               end
            end
            PAYLOAD: begin
               if (!busy) begin
                  if (last_byte) begin
                     pkt_valid <= 1'b0;
                     data_q    <= par ^ {7'b0, corrupt_q};
                     state     <= PARITY;
                  end else begin
                     cnt <= cnt + 6'd1;
                  end
               end
            end
            PARITY: begin
               if (!busy) begin
                  wait_cnt <= WAIT_INIT;
                  data_q   <= '0;
                  state    <= WAIT_ERR;
               end
            end
            WAIT_ERR: begin
               if (wait_cnt == 4'd0) begin
                  pkt_err   <= error;
                  done      <= 1'b1;
                  tx_active <= 1'b0;
                  state     <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
